instr_encoder32: RTL

Program-loader front end and the inverse of the control decoder. Accepts instruction requests as an operation class plus fields, and encodes each into a 32-bit MIPS word (R, I or J format). Buffers the words in a small FIFO and streams them with a word address to the instruction-memory write port over a valid/ready handshake. It feeds instruction memory before and between single-cycle processor runs.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/instr_encoder32.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by the instruction encoder and the control decoder.
// op_sel classes, primary opcodes, R-type funct codes and field bit positions.
package mips_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_SLT = 4'd5,
      OP_BEQ = 4'd6,
      OP_BNE = 4'd7,
      OP_LW  = 4'd8,
      OP_SW  = 4'd9,
      OP_J   = 4'd10
   } op_sel_e;

   localparam logic [5:0] OPC_R   = 6'h00;
   localparam logic [5:0] OPC_J   = 6'h02;
   localparam logic [5:0] OPC_BEQ = 6'h04;
   localparam logic [5:0] OPC_BNE = 6'h05;
   localparam logic [5:0] OPC_LW  = 6'h23;
   localparam logic [5:0] OPC_SW  = 6'h2B;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   localparam int OPC_LSB   = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_LSB   = 0;
   localparam int TGT_LSB   = 0;

   // Classes 11..15 have no encoding.
   function automatic logic is_legal_op(input logic [3:0] op);
      return op <= OP_J;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read so the head word is visible as soon as it is valid.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = count_reg;
   assign dout    = mem_reg[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem_reg[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/instr_encoder32.sv
// Encodes op_sel + fields into 32-bit MIPS words, buffers them and streams them with byte addresses.
// Define ENC_ILLEGAL_TRAP_EN to drop illegal requests and count them on illegal_cnt.
module instr_encoder32
   import mips_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             op_sel,
   input  logic [4:0]             rs,
   input  logic [4:0]             rt,
   input  logic [4:0]             rd,
   input  logic [15:0]            imm,
   input  logic [25:0]            target,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            instr_out,
   output logic [31:0]            instr_addr,
`ifdef ENC_ILLEGAL_TRAP_EN
   output logic [7:0]             illegal_cnt,
`endif
   output logic [$clog2(DEPTH):0] count
);

   logic [31:0] enc_word;
   logic [31:0] instr_addr_reg;
   logic        fifo_full;
   logic        fifo_empty;
   logic        accept;
   logic        push;
   logic        pop;

   always_comb begin
      enc_word = '0;
      case (op_sel_e'(op_sel))
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
            enc_word[OPC_LSB +: 6] = OPC_R;
            enc_word[RS_LSB +: 5]  = rs;
            enc_word[RT_LSB +: 5]  = rt;
            enc_word[RD_LSB +: 5]  = rd;
            case (op_sel_e'(op_sel))
               OP_ADD:  enc_word[FUNCT_LSB +: 6] = FUNCT_ADD;
               OP_SUB:  enc_word[FUNCT_LSB +: 6] = FUNCT_SUB;
               OP_AND:  enc_word[FUNCT_LSB +: 6] = FUNCT_AND;
               OP_OR:   enc_word[FUNCT_LSB +: 6] = FUNCT_OR;
               default: enc_word[FUNCT_LSB +: 6] = FUNCT_SLT;
            endcase
         end
         OP_BEQ, OP_BNE, OP_LW, OP_SW: begin
            case (op_sel_e'(op_sel))
               OP_BEQ:  enc_word[OPC_LSB +: 6] = OPC_BEQ;
               OP_BNE:  enc_word[OPC_LSB +: 6] = OPC_BNE;
               OP_LW:   enc_word[OPC_LSB +: 6] = OPC_LW;
               default: enc_word[OPC_LSB +: 6] = OPC_SW;
            endcase
            enc_word[RS_LSB +: 5]   = rs;
            enc_word[RT_LSB +: 5]   = rt;
            enc_word[IMM_LSB +: 16] = imm;
         end
         OP_J: begin
            enc_word[OPC_LSB +: 6]  = OPC_J;
            enc_word[TGT_LSB +: 26] = target;
         end
         // NOP and the illegal classes both produce the all-zero word.
         default: enc_word = '0;
      endcase
   end

   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
   logic       op_legal;
   logic [7:0] illegal_cnt_reg;

   assign op_legal    = is_legal_op(op_sel);
   assign push        = accept && op_legal;
   assign illegal_cnt = illegal_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_cnt_reg <= '0;
      end else if (accept && !op_legal && illegal_cnt_reg != 8'hFF) begin
         illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
      end
   end
`else
   assign push = accept;
`endif

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (enc_word),
      .pop   (pop),
      .dout  (instr_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign out_valid = !fifo_empty;

   // Address tracks the head word; it advances only when the head is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_addr_reg <= BASE_ADDR;
      end else if (pop) begin
         instr_addr_reg <= instr_addr_reg + 32'd4;
      end
   end

   assign instr_addr = instr_addr_reg;

endmodule
